// File: rtl/fetch_pkg.sv
// Shared types and parameter defaults for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        KILL   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int ADDR_W_DEF   = 16;
    localparam int INSTR_W_DEF  = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int PC_STEP_DEF  = 2;
    localparam int RESET_PC_DEF = 0;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: control inputs, instruction memory port and decode port.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_npc;
    logic               halted;

    modport master (
        input  redirect, redirect_pc, halt, imem_rdata, dec_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_npc, halted
    );

    modport slave (
        output redirect, redirect_pc, halt, imem_rdata, dec_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_npc, halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Power-of-two FIFO holding fetched {npc, instr} entries; synchronous clear wins over push/pop.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (pop_i && !push_i) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited requests, queued responses, redirect/halt flushing.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
//
//   state  | meaning
//   RUN    | fetching sequentially while credits allow
//   KILL   | one cycle after a redirect: drop stale response, request the target
//   HALTED | fetching stopped until reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PC_STEP  = PC_STEP_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC0  = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, infl_addr_q;
    logic              infl_q;
    logic              req, kill_rsp, q_clr, credit;
    logic              rsp_vld, push, pop, q_empty, out_vld;
    logic [CW-1:0]     q_count;
    logic [QW-1:0]     q_head, q_wdata, out_data;

    // Outstanding entries (queued plus in flight) may never exceed the queue size.
    assign credit = (q_count + {{(CW-1){1'b0}}, infl_q}) < CW'(DEPTH);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req      = 1'b0;
        kill_rsp = 1'b0;
        q_clr    = 1'b0;
        case (state_q)
            RUN, KILL: begin
                if (bus.halt) begin
                    state_d  = HALTED;
                    kill_rsp = 1'b1;
                    q_clr    = 1'b1;
                end else if (bus.redirect) begin
                    state_d  = KILL;
                    pc_d     = bus.redirect_pc;
                    kill_rsp = 1'b1;
                    q_clr    = 1'b1;
                end else begin
                    kill_rsp = (state_q == KILL);
                    if (credit) begin
                        req     = 1'b1;
                        pc_d    = pc_q + STEP;
                        state_d = RUN;
                    end
                end
            end
            HALTED:  kill_rsp = 1'b1;
            default: begin
                state_d  = RUN;
                kill_rsp = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pc_q        <= PC0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= req;
            if (req) infl_addr_q <= pc_q;
        end
    end

    assign rsp_vld = infl_q && !kill_rsp;
    assign q_wdata = {infl_addr_q + STEP, bus.imem_rdata};
    assign pop     = !q_empty && bus.dec_ready && !q_clr;

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp      = rsp_vld && q_empty;
    assign push     = rsp_vld && !(byp && bus.dec_ready);
    assign out_vld  = !q_empty || byp;
    assign out_data = q_empty ? q_wdata : q_head;
`else
    assign push     = rsp_vld;
    assign out_vld  = !q_empty;
    assign out_data = q_head;
`endif

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (q_clr),
        .push_i  (push),
        .data_i  (q_wdata),
        .pop_i   (pop),
        .data_o  (q_head),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Request is qualified by rst so nothing is driven while reset is held.
    assign bus.imem_req    = req && rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = out_vld;
    assign bus.instr       = out_vld ? out_data[INSTR_W-1:0] : '0;
    assign bus.instr_npc   = out_vld ? out_data[QW-1:INSTR_W] : '0;
    assign bus.halted      = (state_q == HALTED);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC/instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries (power of two, 2..16).
REQ-004 SHALL have parameter PC_STEP, default 2, meaning PC increment per instruction.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-006 SHALL have port clk, input, 1 bit, meaning single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning asynchronous, active-low reset.
REQ-008 SHALL have port redirect, input, 1 bit, meaning branch/jump taken, flush the fetch path.
REQ-009 SHALL have port redirect_pc, input, ADDR_W bits, meaning target address.
REQ-010 SHALL have port halt, input, 1 bit, meaning halt decoded, stop fetching.
REQ-011 SHALL have port imem_req, output, 1 bit, meaning read request to instruction memory.
REQ-012 SHALL have port imem_addr, output, ADDR_W bits, meaning request address.
REQ-013 SHALL have port imem_rdata, input, INSTR_W bits, meaning read data, valid exactly 1 cycle after imem_req.
REQ-014 SHALL have port dec_ready, input, 1 bit, meaning decode accepts an instruction this cycle.
REQ-015 SHALL have port instr_valid, output, 1 bit, meaning instr/instr_npc hold a valid instruction.
REQ-016 SHALL have port instr, output, INSTR_W bits, meaning fetched instruction.
REQ-017 SHALL have port instr_npc, output, ADDR_W bits, meaning instruction address + PC_STEP.
REQ-018 SHALL have port halted, output, 1 bit, meaning the FSM is in HALTED.

Function
REQ-019 SHALL implement FSM states RUN, KILL and HALTED.
REQ-020 SHALL, in RUN, assert imem_req with imem_addr=pc when count+inflight<DEPTH and no redirect or halt is present; pc advances by PC_STEP, wrapping modulo 2^ADDR_W.
REQ-021 SHALL write imem_rdata with its address+PC_STEP into the queue in the cycle after the request, unless the response is killed.
REQ-022 SHALL present the queue head on instr/instr_npc with instr_valid=1 when the queue is non-empty; pop on instr_valid&&dec_ready.
REQ-023 SHALL, with simultaneous push and pop, keep count unchanged; the queue never overflows (credit rule REQ-020).
REQ-024 SHALL, on redirect in RUN: clear the queue, force instr_valid=0 next cycle, set pc=redirect_pc, go to KILL, issue no request that cycle.
REQ-025 SHALL, in KILL, discard any response to a pre-redirect request, issue a request for redirect_pc, and return to RUN.
REQ-026 SHALL, on halt (any state except HALTED): clear the queue, kill in-flight response, stop requests, enter HALTED; halt beats a simultaneous redirect; a simultaneous pop is ignored.
REQ-027 SHALL, in HALTED, hold imem_req=0, instr_valid=0, halted=1 and ignore redirect until reset.
REQ-028 SHALL, on redirect during KILL, apply the newest redirect_pc and stay in KILL.

Reset
REQ-029 SHALL, on rst low, asynchronously set pc=RESET_PC, state=RUN, queue empty, no inflight, imem_req=0, instr_valid=0, instr=0, instr_npc=0, halted=0.
REQ-030 SHALL issue the first request (RESET_PC) in the first cycle after rst deasserts; a reset mid-operation discards all queued and in-flight data.

Configuration
REQ-031 SHALL honor macro FETCH_BYPASS_EN: when defined, a non-killed response arriving while the queue is empty drives instr_valid in the same cycle (request-to-valid 1 cycle), bypassing the queue if dec_ready=1.
REQ-032 SHALL, without FETCH_BYPASS_EN, always route responses through the queue (request-to-valid 2 cycles).

Structure
REQ-033 SHALL place the state enum (RUN/KILL/HALTED) and parameter defaults in shared package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_queue (parametrised width/DEPTH FIFO, synchronous clear).

Verification
REQ-035 SHALL cover: reset, dec_ready=1 always -> imem_addr 0,2,4,...; instr_npc 2,4,6 in order; latency 2 cycles (1 with FETCH_BYPASS_EN).
REQ-036 SHALL cover: dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests, then imem_req=0; no entry lost when dec_ready returns.
REQ-037 SHALL cover: redirect with redirect_pc=0x0100 while 3 queued and 1 in flight -> none delivered, next instr_npc=0x0102.
REQ-038 SHALL cover: halt and redirect in same cycle -> halted=1 next cycle, imem_req stays 0, later redirects ignored.
REQ-039 SHALL cover: pc=0xFFFE, ADDR_W=16 -> next imem_addr 0x0000, instr_npc 0x0000 for 0xFFFE fetch.
REQ-040 SHALL cover: rst asserted mid-stream with queue full -> all outputs reset immediately, first post-reset request to RESET_PC.
